// File: rtl/forwarding_hazard_unit.sv
// Forwarding select and load-use stall controller for the 5-stage MIPS pipeline.
// Optional stall counter output enabled by FORWARDING_HAZARD_STALL_COUNT_EN.
module forwarding_hazard_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_Dest,
    input  logic                      id_Reg_Write,
    input  logic                      id_Mem_Read,
    input  logic                      flush,
    output logic [1:0]                forward_A,
    output logic [1:0]                forward_B,
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
    output logic [31:0]               stall_Count,
`endif
    output logic                      stall
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(ZERO_REG);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    logic                      ex_v, ex_rw, ex_mr;
    logic [REG_ADDR_WIDTH-1:0] ex_dest;
    logic                      mem_v, mem_rw;
    logic [REG_ADDR_WIDTH-1:0] mem_dest;
    logic                      wb_v, wb_rw;
    logic [REG_ADDR_WIDTH-1:0] wb_dest;

    logic [1:0] fwd_a_nxt, fwd_b_nxt;
    logic       load_hit;

    // Youngest-producer-first priority; a load in EX cannot forward yet.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic                      e_v,
        input logic                      e_rw,
        input logic                      e_mr,
        input logic [REG_ADDR_WIDTH-1:0] e_dest,
        input logic                      m_v,
        input logic                      m_rw,
        input logic [REG_ADDR_WIDTH-1:0] m_dest,
        input logic                      w_v,
        input logic                      w_rw,
        input logic [REG_ADDR_WIDTH-1:0] w_dest
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src == ZERO_ADDR)                              sel = FWD_RF;
        else if (e_v && e_rw && !e_mr && src == e_dest)    sel = FWD_EX;
        else if (m_v && m_rw && src == m_dest)             sel = FWD_MEM;
        else if (w_v && w_rw && src == w_dest)             sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        load_hit  = 1'b0;
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        load_hit  = id_Valid && ex_v && ex_mr && ex_rw && (ex_dest != ZERO_ADDR)
                    && ((ex_dest == id_Rs) || (ex_dest == id_Rt));
        fwd_a_nxt = fwd_sel(id_Rs, ex_v, ex_rw, ex_mr, ex_dest,
                            mem_v, mem_rw, mem_dest, wb_v, wb_rw, wb_dest);
        fwd_b_nxt = fwd_sel(id_Rt, ex_v, ex_rw, ex_mr, ex_dest,
                            mem_v, mem_rw, mem_dest, wb_v, wb_rw, wb_dest);
    end

    // Stall is combinational so an async reset of the EX shadow drops it at once.
    assign stall = load_hit && !flush;

    // Shadow pipeline advance; flush or stall injects a bubble into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v      <= 1'b0;
            ex_rw     <= 1'b0;
            ex_mr     <= 1'b0;
            ex_dest   <= '0;
            mem_v     <= 1'b0;
            mem_rw    <= 1'b0;
            mem_dest  <= '0;
            wb_v      <= 1'b0;
            wb_rw     <= 1'b0;
            wb_dest   <= '0;
            forward_A <= FWD_RF;
            forward_B <= FWD_RF;
        end else begin
            mem_v    <= ex_v;
            mem_rw   <= ex_rw;
            mem_dest <= ex_dest;
            wb_v     <= mem_v;
            wb_rw    <= mem_rw;
            wb_dest  <= mem_dest;
            if (flush || stall) begin
                ex_v      <= 1'b0;
                ex_rw     <= 1'b0;
                ex_mr     <= 1'b0;
                ex_dest   <= '0;
                forward_A <= FWD_RF;
                forward_B <= FWD_RF;
            end else begin
                ex_v      <= id_Valid;
                ex_rw     <= id_Reg_Write;
                ex_mr     <= id_Mem_Read;
                ex_dest   <= id_Dest;
                forward_A <= fwd_a_nxt;
                forward_B <= fwd_b_nxt;
            end
        end
    end

`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
    // Saturating count of stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_Count <= '0;
        end else if (stall && (stall_Count != 32'hFFFF_FFFF)) begin
            stall_Count <= stall_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scenario bench for forwarding_hazard_unit: expected selects queued at issue, compared in EX.
module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_Valid;
    logic [4:0] id_Rs, id_Rt, id_Dest;
    logic       id_Reg_Write, id_Mem_Read, flush;
    logic [1:0] forward_A, forward_B;
    logic       stall;
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
    logic [31:0] stall_Count;
`endif

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
    } fwd_t;

    fwd_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    forwarding_hazard_unit #(.REG_ADDR_WIDTH(5), .ZERO_REG(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_Valid     (id_Valid),
        .id_Rs        (id_Rs),
        .id_Rt        (id_Rt),
        .id_Dest      (id_Dest),
        .id_Reg_Write (id_Reg_Write),
        .id_Mem_Read  (id_Mem_Read),
        .flush        (flush),
        .forward_A    (forward_A),
        .forward_B    (forward_B),
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
        .stall_Count  (stall_Count),
`endif
        .stall        (stall)
    );

    always #5 clk = ~clk;

    // Present one ID slot, check stall this cycle, then check selects once it reaches EX.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dest, input logic rw, input logic mr,
                        input logic fl, input logic exp_stall,
                        input logic [1:0] efa, input logic [1:0] efb, input string name);
        fwd_t e;
        @(negedge clk);
        id_Valid = v; id_Rs = rs; id_Rt = rt; id_Dest = dest;
        id_Reg_Write = rw; id_Mem_Read = mr; flush = fl;
        #1;
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", name, stall, exp_stall);
        end
        exp_q.push_back('{fa: efa, fb: efb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (forward_A !== e.fa) begin
            errors++;
            $display("FAIL %s forward_A: got %b expected %b", name, forward_A, e.fa);
        end
        checks++;
        if (forward_B !== e.fb) begin
            errors++;
            $display("FAIL %s forward_B: got %b expected %b", name, forward_B, e.fb);
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "nop");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_Valid = 1'b1; id_Rs = 5'd8; id_Rt = 5'd8; id_Dest = 5'd9;
        id_Reg_Write = 1'b1; id_Mem_Read = 1'b0; flush = 1'b0;
        #12;
        checks++;
        if (forward_A !== 2'b00 || forward_B !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got A=%b B=%b stall=%b expected 00 00 0",
                     forward_A, forward_B, stall);
        end
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_Count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", stall_Count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        id_Valid = 1'b0; id_Rs = 5'd0; id_Rt = 5'd0; id_Dest = 5'd0; id_Reg_Write = 1'b0;
    endtask

    task automatic test_back_to_back();
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "b2b_add3");
        step(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "b2b_sub4");
        step(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "b2b_add6");
        step(1'b1, 5'd6, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, "b2b_split");
        step(1'b1, 5'd6, 5'd6, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "b2b_rs_eq_rt");
        nop(3);
    endtask

    task automatic test_distance();
        logic [1:0] exp_b [3];
        exp_b[0] = 2'b10; exp_b[1] = 2'b11; exp_b[2] = 2'b00;
        for (int n = 1; n <= 3; n++) begin
            step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "dist_add3");
            nop(n);
            step(1'b1, 5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, exp_b[n-1],
                 $sformatf("dist_or_gap%0d", n));
            nop(3);
        end
    endtask

    task automatic test_load_use();
        step(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "lu_lw8");
        step(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, "lu_stall");
        step(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "lu_replay");
        step(1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11, "lu_after");
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_Count !== 32'd1) begin
            errors++;
            $display("FAIL lu_count: got %0d expected 1", stall_Count);
        end
`endif
        nop(3);
    endtask

    task automatic test_zero_reg();
        step(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "zero_add0");
        step(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "zero_use0");
        step(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "zero_lw0");
        step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "zero_lw_use");
        nop(3);
    endtask

    task automatic test_flush();
        step(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "fl_lw8");
        step(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "fl_killed");
        step(1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, "fl_next");
        nop(3);
    endtask

    task automatic test_reset_mid_stall();
        step(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "rs_add8");
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, "rs_lw9");
        @(negedge clk);
        id_Valid = 1'b1; id_Rs = 5'd9; id_Rt = 5'd9; id_Dest = 5'd10;
        id_Reg_Write = 1'b1; id_Mem_Read = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rs_pre_stall: got %b expected 1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || forward_A !== 2'b00 || forward_B !== 2'b00) begin
            errors++;
            $display("FAIL rs_async_clear: got stall=%b A=%b B=%b expected 0 00 00",
                     stall, forward_A, forward_B);
        end
`ifdef FORWARDING_HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_Count !== 32'd0) begin
            errors++;
            $display("FAIL rs_count: got %0d expected 0", stall_Count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd8, 5'd9, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "rs_first_after");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Sequential forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
- Tracks destination registers of in-flight instructions in internal EX/MEM/WB shadow registers.
- Produces registered 2-bit selectors that drive the two EX-stage 4-input operand muxes (ALU A and B).
- Raises a one-cycle stall on load-use hazards, holding PC and IF/ID while a bubble is inserted into EX.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- ZERO_REG, 0, register index that is never forwarded or stalled on.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- id_Valid  input  1  ID-stage slot holds a real instruction.
- id_Rs  input  REG_ADDR_WIDTH  ID source register A.
- id_Rt  input  REG_ADDR_WIDTH  ID source register B.
- id_Dest  input  REG_ADDR_WIDTH  ID destination register (already resolved rt/rd/31).
- id_Reg_Write  input  1  ID instruction writes the register file.
- id_Mem_Read  input  1  ID instruction is a load.
- flush  input  1  branch/jump taken; kill the ID instruction.
- forward_A  output  2  EX operand-A mux select.
- forward_B  output  2  EX operand-B mux select.
- stall  output  1  hold PC and IF/ID, insert bubble into EX.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Internal shadow stages:
  - ex_{V,Dest,RW,MR}, mem_{V,Dest,RW}, wb_{V,Dest,RW}.
  - Each stage advances every clock: ID to EX, EX to MEM, MEM to WB.
- Reset (asynchronous, active-high): all shadow valids = 0; forward_A = forward_B = 2'b00; stall = 0. Reset mid-stall clears the stall immediately.
- stall (combinational): stall = id_Valid & ex_V & ex_MR & ex_RW & (ex_Dest != ZERO_REG) & (ex_Dest == id_Rs | ex_Dest == id_Rt).
  - flush overrides: stall = 0 when flush = 1.
- EX entry on each clock:
  - If flush or stall: EX receives a bubble (ex_V = 0) and forward_A/forward_B load 2'b00.
  - Otherwise EX loads the ID fields, with ex_V = id_Valid.
- Forward select, computed at ID and registered so it is valid during the following EX cycle. Per source register S (rs → forward_A, rt → forward_B), first match wins:
  1. S == ex_Dest, ex_V & ex_RW, not a load → 2'b01 (EX/MEM ALU result).
  2. S == mem_Dest, mem_V & mem_RW → 2'b10 (MEM/WB result).
  3. S == wb_Dest, wb_V & wb_RW → 2'b11 (retired write-back hold register).
  4. Otherwise → 2'b00 (register-file read).
- S == ZERO_REG always yields 2'b00.
- Load followed one cycle later by a user: one stall cycle. On the next cycle the load sits in MEM, so the user is forwarded 2'b10.
- Both operands may match different stages independently. rs == rt resolves identically on both selects.
- Latency: select and stall valid in the same cycle the consumer is in EX/ID respectively; no extra cycles beyond one load-use bubble.
- A stall never lasts more than one consecutive cycle: the load leaves EX after one edge.

Optional Feature:
- Macro: FORWARDING_HAZARD_STALL_COUNT_EN.
- When defined:
  - Adds output stall_Count[31:0], which increments on every clock where stall = 1.
  - The count saturates at 32'hFFFF_FFFF and is reset to 0 by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back → forward_A = 01, forward_B = 00 in sub's EX cycle, stall = 0.
- add $3 then nop then or $6,$7,$3 → forward_B = 10 in or's EX cycle; with two nops → forward_B = 11; with three nops → 00.
- lw $8,0($1) then add $9,$8,$8 → stall = 1 exactly one cycle, bubble in EX, then forward_A = forward_B = 10; stall count (if enabled) = 1.
- Writes to $0 (add $0,$1,$2 then add $5,$0,$0) → selects 00, stall = 0; lw $0 followed by a user → no stall.
- lw $8 then a user of $8 while flush = 1 → stall = 0, EX gets bubble, selects 00.
- Assert rst mid-stall (lw/use pair) → stall drops asynchronously, selects 00; after release, the first instruction sees no forwarding.
